sprite_line_draw: RTL

Per-scanline sprite renderer that sits directly upstream of the sprite graphics ROM. On each line-start pulse it decides whether the current screen line crosses the sprite. If it does, it walks the ROM addresses for that sprite row while the beam crosses the sprite's columns. It returns registered colour indices with a `drawing` qualifier to the palette/compositing stage.

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_line_draw.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/sprite_pkg.sv
// Shared types and width helpers for the per-scanline sprite renderer.
package sprite_pkg;

    // Line-processing states, in the order a normal line walks through them.
    typedef enum logic [2:0] {
        IDLE,
        REG_POS,
        ACTIVE,
        WAIT_POS,
        SPR_LINE,
        DONE
    } sprite_state_t;

    // Sprite ROM address width for a WIDTH x HEIGHT sprite.
    function automatic int addr_width(input int width, input int height);
        return (width * height > 1) ? $clog2(width * height) : 1;
    endfunction

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_line_draw.sv
// Per-scanline sprite renderer: decides whether the current line crosses the
// sprite, then walks the ROM row while the beam crosses the sprite columns.
module sprite_line_draw
    import sprite_pkg::*;
#(
    parameter int WIDTH   = 8,
    parameter int HEIGHT  = 8,
    parameter int SCALE_X = 1,
    parameter int SCALE_Y = 1,
    parameter int COLRW   = 4,
    parameter int CORDW   = 16,
    localparam int ADDRW  = addr_width(WIDTH, HEIGHT)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    oe,
    input  logic signed [CORDW-1:0] sx,
    input  logic signed [CORDW-1:0] sy,
    input  logic signed [CORDW-1:0] sprx,
    input  logic signed [CORDW-1:0] spry,
    output logic [ADDRW-1:0]        rom_addr,
    input  logic [COLRW-1:0]        rom_data,
    output logic [COLRW-1:0]        pix,
    output logic                    drawing,
    output logic                    done
);

    // Scales and width are powers of two, so row/column maths are shifts.
    localparam int XSH    = $clog2(SCALE_X);
    localparam int YSH    = $clog2(SCALE_Y);
    localparam int WSH    = $clog2(WIDTH);
    localparam int LINE_H = HEIGHT * SCALE_Y;
    localparam int CW     = cnt_width(WIDTH);
    localparam int SW     = cnt_width(SCALE_X);

    sprite_state_t state, state_next;

    logic signed [CORDW-1:0] sprx_r;
    logic signed [CORDW-1:0] spry_r;
    logic [CW-1:0]           col_cnt;
    logic [SW-1:0]           scale_cnt;

    // One extra bit keeps the bottom-edge sum from wrapping near the top of the range.
    logic signed [CORDW:0]   sy_x;
    logic signed [CORDW:0]   top_x;
    logic signed [CORDW:0]   bot_x;
    logic [CORDW:0]          row_off;
    logic [ADDRW-1:0]        row_base;
    logic signed [CORDW-1:0] sprx_m1;
    logic                    line_hit;
    logic                    at_left;
    logic                    scale_wrap;
    logic                    last_px;

    assign sy_x     = {sy[CORDW-1], sy};
    assign top_x    = {spry_r[CORDW-1], spry_r};
    assign bot_x    = top_x + (CORDW+1)'(LINE_H);
    assign line_hit = (sy_x >= top_x) && (sy_x < bot_x);
    assign row_off  = sy_x - top_x;
    assign row_base = ADDRW'((row_off >> YSH) << WSH);

    assign sprx_m1    = sprx_r - CORDW'(1);
    assign at_left    = oe && (sx == sprx_m1);
    assign scale_wrap = (scale_cnt == SW'(SCALE_X - 1));
    assign last_px    = (col_cnt == CW'(WIDTH - 1)) && scale_wrap;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic; start restarts the line from any state.
    always_comb begin
        // NOTE: default first so no path leaves state_next unassigned and infers a latch.
        state_next = state;
        if (start) begin
            state_next = REG_POS;
        end else begin
            case (state)
                IDLE:     state_next = IDLE;
                REG_POS:  state_next = ACTIVE;
                ACTIVE:   state_next = line_hit ? WAIT_POS : DONE;
                WAIT_POS: if (at_left) state_next = SPR_LINE;
                SPR_LINE: if (oe && last_px) state_next = DONE;
                DONE:     state_next = IDLE;
                default:  state_next = IDLE;
            endcase
        end
    end

    // Position latch, ROM address walk, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sprx_r    <= '0;
            spry_r    <= '0;
            rom_addr  <= '0;
            pix       <= '0;
            drawing   <= 1'b0;
            done      <= 1'b0;
            col_cnt   <= '0;
            scale_cnt <= '0;
        end else begin
            done <= (state_next == DONE);
            if (start) begin
                drawing <= 1'b0;
            end else begin
                case (state)
                    REG_POS: begin
                        sprx_r <= sprx;
                        spry_r <= spry;
                        if (oe) drawing <= 1'b0;
                    end
                    ACTIVE: begin
                        if (line_hit) rom_addr <= row_base;
                        if (oe) drawing <= 1'b0;
                    end
                    WAIT_POS: begin
                        col_cnt   <= '0;
                        scale_cnt <= '0;
                        if (oe) drawing <= 1'b0;
                    end
                    SPR_LINE: begin
                        if (oe) begin
                            pix     <= rom_data;
                            drawing <= 1'b1;
                            if (scale_wrap) begin
                                scale_cnt <= '0;
                                // The last column keeps its address so it never leaves the sprite.
                                if (!last_px) begin
                                    col_cnt  <= col_cnt + CW'(1);
                                    rom_addr <= rom_addr + ADDRW'(1);
                                end
                            end else begin
                                scale_cnt <= scale_cnt + SW'(1);
                            end
                        end
                    end
                    default: begin
                        if (oe) drawing <= 1'b0;
                    end
                endcase
            end
        end
    end

    // XSH is only meaningful through SCALE_X; keep it referenced for readers.
    logic unused_xsh;
    assign unused_xsh = (XSH < 0);

endmodule
